// File: rtl/total_zeros_dec.sv
// Bit-serial CAVLC total_zeros decoder (4x4 blocks): shifts in one bit per transfer
// and matches the growing prefix against the total_zeros VLC table chosen by TotalCoeff.
module total_zeros_dec #(
   parameter int MAX_LEN = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] total_coeff,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] total_zeros,
   output logic [3:0] code_len
);

   // state | meaning
   // IDLE  | waiting for start
   // SHIFT | accepting bits, matching prefix after each transfer
   // DONE  | one-cycle done pulse
   // ERR   | one-cycle err pulse (illegal TotalCoeff or no match in MAX_LEN bits)
   typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

   state_t             state;
   logic [3:0]         tc;
   logic [3:0]         len;
   logic [MAX_LEN-1:0] shreg;
   logic [3:0]         len_nx;
   logic [MAX_LEN-1:0] shreg_nx;
   logic [4:0]         hit_tz;

   function automatic logic [4:0] hit(input logic [3:0] v);
      return {1'b1, v};
   endfunction

   // Returns {match, total_zeros}; the code is right-aligned in c with zeros above it.
   function automatic logic [4:0] lookup(input logic [3:0] t, input logic [3:0] n,
                                         input logic [MAX_LEN-1:0] c);
      logic [MAX_LEN+3:0] k;
      logic [4:0]         r;
      k = {n, c};
      r = '0;
      case (t)
         4'd1: case (k)
            {4'd1,9'b1}:         r = hit(4'd0);  {4'd3,9'b011}:       r = hit(4'd1);
            {4'd3,9'b010}:       r = hit(4'd2);  {4'd4,9'b0011}:      r = hit(4'd3);
            {4'd4,9'b0010}:      r = hit(4'd4);  {4'd5,9'b00011}:     r = hit(4'd5);
            {4'd5,9'b00010}:     r = hit(4'd6);  {4'd6,9'b000011}:    r = hit(4'd7);
            {4'd6,9'b000010}:    r = hit(4'd8);  {4'd7,9'b0000011}:   r = hit(4'd9);
            {4'd7,9'b0000010}:   r = hit(4'd10); {4'd8,9'b00000011}:  r = hit(4'd11);
            {4'd8,9'b00000010}:  r = hit(4'd12); {4'd9,9'b000000011}: r = hit(4'd13);
            {4'd9,9'b000000010}: r = hit(4'd14); {4'd9,9'b000000001}: r = hit(4'd15);
            default: r = '0;
         endcase
         4'd2: case (k)
            {4'd3,9'b111}:    r = hit(4'd0);  {4'd3,9'b110}:    r = hit(4'd1);
            {4'd3,9'b101}:    r = hit(4'd2);  {4'd3,9'b100}:    r = hit(4'd3);
            {4'd3,9'b011}:    r = hit(4'd4);  {4'd4,9'b0101}:   r = hit(4'd5);
            {4'd4,9'b0100}:   r = hit(4'd6);  {4'd4,9'b0011}:   r = hit(4'd7);
            {4'd4,9'b0010}:   r = hit(4'd8);  {4'd5,9'b00011}:  r = hit(4'd9);
            {4'd5,9'b00010}:  r = hit(4'd10); {4'd6,9'b000011}: r = hit(4'd11);
            {4'd6,9'b000010}: r = hit(4'd12); {4'd6,9'b000001}: r = hit(4'd13);
            {4'd6,9'b000000}: r = hit(4'd14);
            default: r = '0;
         endcase
         4'd3: case (k)
            {4'd4,9'b0101}:   r = hit(4'd0);  {4'd3,9'b111}:    r = hit(4'd1);
            {4'd3,9'b110}:    r = hit(4'd2);  {4'd3,9'b101}:    r = hit(4'd3);
            {4'd4,9'b0100}:   r = hit(4'd4);  {4'd4,9'b0011}:   r = hit(4'd5);
            {4'd3,9'b100}:    r = hit(4'd6);  {4'd3,9'b011}:    r = hit(4'd7);
            {4'd4,9'b0010}:   r = hit(4'd8);  {4'd5,9'b00011}:  r = hit(4'd9);
            {4'd5,9'b00010}:  r = hit(4'd10); {4'd6,9'b000001}: r = hit(4'd11);
            {4'd5,9'b00001}:  r = hit(4'd12); {4'd6,9'b000000}: r = hit(4'd13);
            default: r = '0;
         endcase
         4'd4: case (k)
            {4'd5,9'b00011}:  r = hit(4'd0);  {4'd3,9'b111}:    r = hit(4'd1);
            {4'd4,9'b0101}:   r = hit(4'd2);  {4'd4,9'b0100}:   r = hit(4'd3);
            {4'd3,9'b110}:    r = hit(4'd4);  {4'd3,9'b101}:    r = hit(4'd5);
            {4'd3,9'b100}:    r = hit(4'd6);  {4'd4,9'b0011}:   r = hit(4'd7);
            {4'd3,9'b011}:    r = hit(4'd8);  {4'd4,9'b0010}:   r = hit(4'd9);
            {4'd5,9'b00010}:  r = hit(4'd10); {4'd5,9'b00001}:  r = hit(4'd11);
            {4'd5,9'b00000}:  r = hit(4'd12);
            default: r = '0;
         endcase
         4'd5: case (k)
            {4'd4,9'b0101}:   r = hit(4'd0);  {4'd4,9'b0100}:   r = hit(4'd1);
            {4'd4,9'b0011}:   r = hit(4'd2);  {4'd3,9'b111}:    r = hit(4'd3);
            {4'd3,9'b110}:    r = hit(4'd4);  {4'd3,9'b101}:    r = hit(4'd5);
            {4'd3,9'b100}:    r = hit(4'd6);  {4'd4,9'b0010}:   r = hit(4'd7);
            {4'd3,9'b011}:    r = hit(4'd8);  {4'd5,9'b00001}:  r = hit(4'd9);
            {4'd4,9'b0001}:   r = hit(4'd10); {4'd5,9'b00000}:  r = hit(4'd11);
            default: r = '0;
         endcase
         4'd6: case (k)
            {4'd6,9'b000001}: r = hit(4'd0);  {4'd5,9'b00001}:  r = hit(4'd1);
            {4'd3,9'b111}:    r = hit(4'd2);  {4'd3,9'b110}:    r = hit(4'd3);
            {4'd3,9'b101}:    r = hit(4'd4);  {4'd3,9'b100}:    r = hit(4'd5);
            {4'd3,9'b011}:    r = hit(4'd6);  {4'd3,9'b010}:    r = hit(4'd7);
            {4'd4,9'b0001}:   r = hit(4'd8);  {4'd3,9'b001}:    r = hit(4'd9);
            {4'd6,9'b000000}: r = hit(4'd10);
            default: r = '0;
         endcase
         4'd7: case (k)
            {4'd6,9'b000001}: r = hit(4'd0);  {4'd5,9'b00001}:  r = hit(4'd1);
            {4'd3,9'b101}:    r = hit(4'd2);  {4'd3,9'b100}:    r = hit(4'd3);
            {4'd3,9'b011}:    r = hit(4'd4);  {4'd2,9'b11}:     r = hit(4'd5);
            {4'd3,9'b010}:    r = hit(4'd6);  {4'd4,9'b0001}:   r = hit(4'd7);
            {4'd3,9'b001}:    r = hit(4'd8);  {4'd6,9'b000000}: r = hit(4'd9);
            default: r = '0;
         endcase
         4'd8: case (k)
            {4'd6,9'b000001}: r = hit(4'd0);  {4'd4,9'b0001}:   r = hit(4'd1);
            {4'd5,9'b00001}:  r = hit(4'd2);  {4'd3,9'b011}:    r = hit(4'd3);
            {4'd2,9'b11}:     r = hit(4'd4);  {4'd2,9'b10}:     r = hit(4'd5);
            {4'd3,9'b010}:    r = hit(4'd6);  {4'd3,9'b001}:    r = hit(4'd7);
            {4'd6,9'b000000}: r = hit(4'd8);
            default: r = '0;
         endcase
         4'd9: case (k)
            {4'd6,9'b000001}: r = hit(4'd0);  {4'd6,9'b000000}: r = hit(4'd1);
            {4'd4,9'b0001}:   r = hit(4'd2);  {4'd2,9'b11}:     r = hit(4'd3);
            {4'd2,9'b10}:     r = hit(4'd4);  {4'd3,9'b001}:    r = hit(4'd5);
            {4'd2,9'b01}:     r = hit(4'd6);  {4'd5,9'b00001}:  r = hit(4'd7);
            default: r = '0;
         endcase
         4'd10: case (k)
            {4'd5,9'b00001}:  r = hit(4'd0);  {4'd5,9'b00000}:  r = hit(4'd1);
            {4'd3,9'b001}:    r = hit(4'd2);  {4'd2,9'b11}:     r = hit(4'd3);
            {4'd2,9'b10}:     r = hit(4'd4);  {4'd2,9'b01}:     r = hit(4'd5);
            {4'd4,9'b0001}:   r = hit(4'd6);
            default: r = '0;
         endcase
         4'd11: case (k)
            {4'd4,9'b0000}:   r = hit(4'd0);  {4'd4,9'b0001}:   r = hit(4'd1);
            {4'd3,9'b001}:    r = hit(4'd2);  {4'd3,9'b010}:    r = hit(4'd3);
            {4'd1,9'b1}:      r = hit(4'd4);  {4'd3,9'b011}:    r = hit(4'd5);
            default: r = '0;
         endcase
         4'd12: case (k)
            {4'd4,9'b0000}:   r = hit(4'd0);  {4'd4,9'b0001}:   r = hit(4'd1);
            {4'd2,9'b01}:     r = hit(4'd2);  {4'd1,9'b1}:      r = hit(4'd3);
            {4'd3,9'b001}:    r = hit(4'd4);
            default: r = '0;
         endcase
         4'd13: case (k)
            {4'd3,9'b000}:    r = hit(4'd0);  {4'd3,9'b001}:    r = hit(4'd1);
            {4'd1,9'b1}:      r = hit(4'd2);  {4'd2,9'b01}:     r = hit(4'd3);
            default: r = '0;
         endcase
         4'd14: case (k)
            {4'd2,9'b00}:     r = hit(4'd0);  {4'd2,9'b01}:     r = hit(4'd1);
            {4'd1,9'b1}:      r = hit(4'd2);
            default: r = '0;
         endcase
         4'd15: case (k)
            {4'd1,9'b0}:      r = hit(4'd0);  {4'd1,9'b1}:      r = hit(4'd1);
            default: r = '0;
         endcase
         default: r = '0;
      endcase
      return r;
   endfunction

   assign len_nx   = len + 4'd1;
   assign shreg_nx = {shreg[MAX_LEN-2:0], bit_in};
   assign hit_tz   = lookup(tc, len_nx, shreg_nx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tc          <= '0;
         len         <= '0;
         shreg       <= '0;
         bit_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         total_zeros <= '0;
         code_len    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (total_coeff != 5'd0 && !total_coeff[4]) begin
                     tc        <= total_coeff[3:0];
                     len       <= '0;
                     shreg     <= '0;
                     bit_ready <= 1'b1;
                     state     <= SHIFT;
                  end else begin
                     code_len <= '0;
                     err      <= 1'b1;
                     state    <= ERR;
                  end
               end
            end
            SHIFT: begin
               if (bit_valid) begin
                  len   <= len_nx;
                  shreg <= shreg_nx;
                  if (hit_tz[4]) begin
                     total_zeros <= hit_tz[3:0];
                     code_len    <= len_nx;
                     done        <= 1'b1;
                     bit_ready   <= 1'b0;
                     state       <= DONE;
                  end else if (len_nx == 4'(MAX_LEN)) begin
                     code_len  <= 4'(MAX_LEN);
                     err       <= 1'b1;
                     bit_ready <= 1'b0;
                     state     <= ERR;
                  end
               end
            end
            default: begin
               done      <= 1'b0;
               err       <= 1'b0;
               busy      <= 1'b0;
               bit_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
